// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage with a fixed-latency multi-cycle access.
// An aligned load/store seen in IDLE latches its operands, waits WAIT_CYCLES
// extra cycles in BUSY, performs the access on the last BUSY edge, and
// spends one cycle in DONE so the released pipeline cannot re-issue it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; aligned request starts one
// BUSY  | counting down wait cycles; access happens when cnt reaches 0
// DONE  | access complete, stall released; inputs are not a new request
module data_mem_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] ALUresult,
  input  logic [31:0] writeData,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [4:0]  writeReg,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        addrError,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [31:0] ALUresultOut,
  output logic [4:0]  writeRegOut
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;          // latched op: 1 = store (wins over load), 0 = load
  logic [31:0]   rdata_q, rdata_d;
  logic          addr_err_q, addr_err_d;

  logic [31:0]   mem [DEPTH];

  logic req, aligned, start, access, mem_we;

  assign req     = memRead | memWrite;
  assign aligned = (ALUresult[1:0] == 2'b00);
  assign start   = (state_q == IDLE) && req && aligned;
  assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
  // async reset forces IDLE immediately, so an aborted access can never reach this edge
  assign mem_we  = access && wr_q;

  assign readData     = rdata_q;
  assign addrError    = addr_err_q;
  assign RegWriteOut  = RegWrite;
  assign MemtoRegOut  = MemtoReg;
  assign ALUresultOut = ALUresult;
  assign writeRegOut  = writeReg;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      rdata_q    <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory array: no reset, contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, wait counter, load data and misalignment flag
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    addr_err_d = (state_q == IDLE) && req && !aligned;
    if (start) begin
      cnt_d   = 4'(WAIT_CYCLES);
      idx_d   = ALUresult[AW+1:2];
      wdata_d = writeData;
      wr_d    = memWrite;
    end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (access && !wr_q) rdata_d = mem[idx_q];
  end

  // Outputs: stall covers the request cycle and all of BUSY, held low in reset
  always_comb begin
    memStall = 1'b0;
    if (!rst) memStall = start || (state_q == BUSY);
  end

endmodule
